voice_allocator: RTL

Polyphonic voice allocator sitting directly downstream of the touch/note decode stage. Consumes the 24 per-key gate levels and one-cycle rising-edge triggers, and assigns pressed keys to a fixed pool of synthesis voices. Per voice it produces a key index, a held gate, and a one-cycle retrigger pulse for the oscillator/envelope stages. Simultaneous presses are queued and serviced one per cycle. When the pool is exhausted, voices are stolen round-robin.

---
 rtl/voice_allocator.sv | 92 +++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: queues key presses, services one per cycle onto a
// fixed voice pool, and steals voices round-robin when the pool is exhausted.
module voice_allocator #(
    parameter int unsigned NUM_KEYS   = 24,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned KW         = $clog2(NUM_KEYS)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_KEYS-1:0]        gate_in,
    input  logic [NUM_KEYS-1:0]        trigger_in,
    output logic [NUM_VOICES*KW-1:0]   voice_note_out,
    output logic [NUM_VOICES-1:0]      voice_gate_out,
    output logic [NUM_VOICES-1:0]      voice_trigger_out,
    output logic                       all_busy_out
);

    localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_KEYS-1:0]   pending;
    logic [KW-1:0]         voice_note [NUM_VOICES];
    logic [VW-1:0]         steal_ptr;

    logic [NUM_KEYS-1:0]   cand;
    logic [NUM_KEYS-1:0]   pending_nxt;
    logic                  svc_valid;
    logic [KW-1:0]         svc_key;
    logic [NUM_VOICES-1:0] releasing;
    logic                  has_free;
    logic [VW-1:0]         free_idx;
    logic [VW-1:0]         target;

    // Pick the lowest live candidate key and the voice it lands on.
    always_comb begin
        cand      = (pending | trigger_in) & gate_in;
        svc_valid = 1'b0;
        svc_key   = '0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (cand[k] && !svc_valid) begin
                svc_valid = 1'b1;
                svc_key   = KW'(k);
            end
        end
        pending_nxt = svc_valid ? (cand & ~(NUM_KEYS'(1) << svc_key)) : cand;

        releasing = '0;
        has_free  = 1'b0;
        free_idx  = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            releasing[v] = voice_gate_out[v] & ~gate_in[voice_note[v]];
            if ((!voice_gate_out[v] || releasing[v]) && !has_free) begin
                has_free = 1'b1;
                free_idx = VW'(v);
            end
        end
        target = has_free ? free_idx : steal_ptr;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending           <= '0;
            steal_ptr         <= '0;
            voice_gate_out    <= '0;
            voice_trigger_out <= '0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                voice_note[v] <= '0;
            end
        end else begin
            pending           <= pending_nxt;
            voice_gate_out    <= voice_gate_out & ~releasing;
            voice_trigger_out <= '0;
            if (svc_valid) begin
                voice_note[target]        <= svc_key;
                voice_gate_out[target]    <= 1'b1;
                voice_trigger_out[target] <= 1'b1;
                if (!has_free) begin
                    steal_ptr <= steal_ptr + VW'(1);
                end
            end
        end
    end

    always_comb begin
        voice_note_out = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            voice_note_out[v*KW +: KW] = voice_note[v];
        end
    end

    assign all_busy_out = &voice_gate_out;

endmodule
